vip_uart_rx_multi: RTL

VIP_UART_RX_MULTI -- requirements
Module: vip_uart_rx_multi

---
 rtl/vip_uart_pkg.sv | 24 ++
 rtl/vip_uart_rx_chan.sv | 141 ++++++++++++++
 rtl/vip_uart_rx_multi.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vip_uart_pkg.sv
// Shared types and constants for the multi-channel UART receiver.
//   rx_state_e   : per-channel receive FSM states
//   uart_frame_t : FIFO payload {channel, data byte}
package vip_uart_pkg;

  localparam int unsigned DataBits   = 8;
  localparam int unsigned MinDiv     = 2;
  // Wide enough for the largest supported channel count (16).
  localparam int unsigned ChanFieldW = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef struct packed {
    logic [ChanFieldW-1:0] chan;
    logic [DataBits-1:0]   data;
  } uart_frame_t;

endpackage

// File: rtl/vip_uart_rx_chan.sv
// One UART receive channel: 2-FF synchroniser, frame FSM with bit counter,
// and a 1-entry holding register drained by the top-level arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   clk_div    : clk cycles per UART bit (clamped to MinDiv)
//   parity_en  : even-parity bit follows the data bits
//   rx         : asynchronous serial input, idle high
//   grant      : arbiter takes the holding entry this cycle
//   hold_valid : holding register full
//   hold_data  : held byte
//   frame_err  : one-cycle pulse on framing or parity error
//   overflow   : one-cycle pulse when a completed byte is dropped
module vip_uart_rx_chan
  import vip_uart_pkg::*;
#(
  parameter int unsigned DivWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DivWidth-1:0] clk_div,
  input  logic                parity_en,
  input  logic                rx,
  input  logic                grant,
  output logic                hold_valid,
  output logic [DataBits-1:0] hold_data,
  output logic                frame_err,
  output logic                overflow
);

  localparam int unsigned BitIdxW = $clog2(DataBits);

  logic                sync1_q, sync2_q, line_hi_q;
  logic [1:0]          flush_q;
  rx_state_e           state_q, state_d;
  logic [DivWidth-1:0] cnt_q, div_q;
  logic [BitIdxW-1:0]  bit_idx_q;
  logic [DataBits-1:0] shift_q;
  logic                par_err_q;
  logic                start_edge_c, tick_c, byte_done_c, err_c;
  logic [DivWidth-1:0] div_eff_c;

  // line_hi_q only reports a high level once the synchroniser holds a real
  // post-reset sample, so a line held low through reset never looks like a
  // start edge.
  assign start_edge_c = line_hi_q & ~sync2_q;
  assign tick_c       = (cnt_q == '0);
  assign div_eff_c    = (clk_div < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : clk_div;

  // Synchroniser and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      flush_q   <= '0;
      line_hi_q <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      flush_q   <= {flush_q[0], 1'b1};
      line_hi_q <= flush_q[1] & sync2_q;
    end
  end

  // Next-state logic and frame-end strobes.
  always_comb begin
    state_d     = state_q;
    byte_done_c = 1'b0;
    err_c       = 1'b0;
    case (state_q)
      IDLE:   if (start_edge_c) state_d = START;
      START:  if (tick_c) state_d = sync2_q ? IDLE : DATA;
      DATA: begin
        if (tick_c && (bit_idx_q == BitIdxW'(DataBits - 1)))
          state_d = parity_en ? PARITY : STOP;
      end
      PARITY: if (tick_c) state_d = STOP;
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          if (!sync2_q || par_err_q) err_c = 1'b1;
          else                       byte_done_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DivWidth'(MinDiv);
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (start_edge_c) begin
          div_q     <= div_eff_c;
          cnt_q     <= div_eff_c >> 1;
          bit_idx_q <= '0;
          par_err_q <= 1'b0;
        end
      end else if (tick_c) begin
        cnt_q <= div_q - DivWidth'(1);
        if (state_q == DATA) begin
          shift_q   <= {sync2_q, shift_q[DataBits-1:1]};
          bit_idx_q <= bit_idx_q + BitIdxW'(1);
        end
        if (state_q == PARITY) par_err_q <= ^{shift_q, sync2_q};
      end else begin
        cnt_q <= cnt_q - DivWidth'(1);
      end
    end
  end

  // Holding register; a grant in the same cycle frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err <= err_c;
      overflow  <= 1'b0;
      if (byte_done_c) begin
        if (hold_valid && !grant) begin
          overflow <= 1'b1;
        end else begin
          hold_valid <= 1'b1;
          hold_data  <= shift_q;
        end
      end else if (grant) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vip_uart_rx_multi.sv
// Multi-channel UART receiver: NumChan receive channels merged by a
// round-robin arbiter into one shared FIFO with a valid/ready output.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clk_div_i     : clk cycles per UART bit for all channels
//   parity_en_i   : even parity present
//   uart_rx_i     : serial lines, idle high
//   valid_o/ready_i/data_o/chan_o : received-byte stream
//   frame_err_o   : per-channel framing/parity error pulse
//   overflow_o    : per-channel dropped-byte pulse
module vip_uart_rx_multi
  import vip_uart_pkg::*;
#(
  parameter int unsigned NumChan   = 1,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned DivWidth  = 16,
  localparam int unsigned ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DivWidth-1:0] clk_div_i,
  input  logic                parity_en_i,
  input  logic [NumChan-1:0]  uart_rx_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DataBits-1:0] data_o,
  output logic [ChanW-1:0]    chan_o,
  output logic [NumChan-1:0]  frame_err_o,
  output logic [NumChan-1:0]  overflow_o
);

  localparam int unsigned AddrW = $clog2(FifoDepth);

  logic [NumChan-1:0]  hold_valid, grant;
  logic [DataBits-1:0] hold_data [NumChan];
  logic [ChanW-1:0]    rr_ptr_q, gnt_idx_c;
  logic [DataBits-1:0] gnt_data_c;
  logic                gnt_any_c;
  uart_frame_t         frame_c, head_c;
  uart_frame_t         mem_q [FifoDepth];
  logic [AddrW:0]      wr_ptr_q, rd_ptr_q;
  logic                empty_c, full_c, push_c, pop_c;

  for (genvar c = 0; c < int'(NumChan); c++) begin : g_chan
    vip_uart_rx_chan #(.DivWidth(DivWidth)) u_chan (
      .clk        (clk_i),
      .rst        (rst_i),
      .clk_div    (clk_div_i),
      .parity_en  (parity_en_i),
      .rx         (uart_rx_i[c]),
      .grant      (grant[c]),
      .hold_valid (hold_valid[c]),
      .hold_data  (hold_data[c]),
      .frame_err  (frame_err_o[c]),
      .overflow   (overflow_o[c])
    );
  end

  // Round-robin pick: first pass from the pointer upward, second pass wraps.
  always_comb begin
    gnt_any_c  = 1'b0;
    gnt_idx_c  = '0;
    gnt_data_c = '0;
    for (int c = 0; c < int'(NumChan); c++) begin
      if (!gnt_any_c && hold_valid[c] && (ChanW'(c) >= rr_ptr_q)) begin
        gnt_any_c  = 1'b1;
        gnt_idx_c  = ChanW'(c);
        gnt_data_c = hold_data[c];
      end
    end
    for (int c = 0; c < int'(NumChan); c++) begin
      if (!gnt_any_c && hold_valid[c]) begin
        gnt_any_c  = 1'b1;
        gnt_idx_c  = ChanW'(c);
        gnt_data_c = hold_data[c];
      end
    end
  end

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop_c   = !empty_c && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_c  = gnt_any_c && (!full_c || pop_c);

  always_comb begin
    grant = '0;
    for (int c = 0; c < int'(NumChan); c++)
      grant[c] = push_c && (gnt_idx_c == ChanW'(c));
  end

  assign frame_c.chan = ChanFieldW'(gnt_idx_c);
  assign frame_c.data = gnt_data_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
        rr_ptr_q <= (gnt_idx_c == ChanW'(NumChan - 1)) ? '0 : gnt_idx_c + ChanW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
    end
  end

  // FIFO storage needs no reset; the pointers qualify its contents.
  always_ff @(posedge clk_i) begin
    if (push_c && !rst_i) mem_q[wr_ptr_q[AddrW-1:0]] <= frame_c;
  end

  assign head_c  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign valid_o = !empty_c;
  assign data_o  = empty_c ? '0 : head_c.data;

  // Decode the stored channel field back to the port width.
  always_comb begin
    chan_o = '0;
    for (int c = 0; c < int'(NumChan); c++)
      if (!empty_c && (head_c.chan == ChanFieldW'(c))) chan_o = ChanW'(c);
  end

endmodule
